// File: rtl/cjg_shift_sequencer_if.sv
// Execute-side request/response bundle plus the single-step shifter link
// for cjg_shift_sequencer.
interface cjg_shift_sequencer_if #(
   parameter int WIDTH     = 32,
   parameter int AMT_WIDTH = 6
);
   logic                 start;
   logic [2:0]           opcode;
   logic [WIDTH-1:0]     operand;
   logic                 carry_in;
   logic [AMT_WIDTH-1:0] amount;

   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     result;
   logic                 carry_out;

   logic [WIDTH-1:0]     sh_operand;
   logic                 sh_carry_in;
   logic [2:0]           sh_opcode;
   logic [WIDTH-1:0]     sh_result;
   logic                 sh_carry_out;

   // The sequencer is the slave; the execute stage plus shifter form the master.
   modport slave (
      input  start, opcode, operand, carry_in, amount, sh_result, sh_carry_out,
      output ready, busy, done, result, carry_out, sh_operand, sh_carry_in, sh_opcode
   );

   modport master (
      output start, opcode, operand, carry_in, amount, sh_result, sh_carry_out,
      input  ready, busy, done, result, carry_out, sh_operand, sh_carry_in, sh_opcode
   );
endinterface

// File: rtl/cjg_shift_sequencer.sv
// Multi-cycle shift/rotate controller: drives a 1-bit-per-cycle shifter
// until the effective amount is consumed, then reports result with a done pulse.
module cjg_shift_sequencer #(
   parameter int WIDTH     = 32,
   parameter int AMT_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   cjg_shift_sequencer_if.slave  bus
);
   localparam logic [2:0] OP_SRL = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_RTR = 3'd3;
   localparam logic [2:0] OP_RTL = 3'd4;
   localparam logic [2:0] OP_RRC = 3'd5;
   localparam logic [2:0] OP_RLC = 3'd6;

   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam int EXT_W = ((AMT_WIDTH > CNT_W) ? AMT_WIDTH : CNT_W) + 1;
   localparam logic [EXT_W-1:0] W_EXT  = EXT_W'(WIDTH);
   localparam logic [EXT_W-1:0] W1_EXT = EXT_W'(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             work_c_q, work_c_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [EXT_W-1:0] amt_ext;
   logic [CNT_W-1:0] n_eff;
   logic             accept;

   assign amt_ext = EXT_W'(bus.amount);
   assign accept  = (state_q == S_IDLE) && ready_q && bus.start;

   // Plain shifts saturate at WIDTH; rotates wrap, and the carry ring is one bit longer.
   always_comb begin
      n_eff = '0;
      case (bus.opcode)
         OP_SRL, OP_SLL, OP_SRA: n_eff = (amt_ext > W_EXT) ? CNT_W'(WIDTH) : CNT_W'(amt_ext);
         OP_RTR, OP_RTL:         n_eff = CNT_W'(amt_ext % W_EXT);
         OP_RRC, OP_RLC:         n_eff = CNT_W'(amt_ext % W1_EXT);
         default:                n_eff = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      work_c_d = work_c_q;
      count_d  = count_q;
      op_d     = op_q;
      result_d = result_q;
      carry_d  = carry_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               work_d   = bus.operand;
               work_c_d = bus.carry_in;
               op_d     = bus.opcode;
               count_d  = n_eff;
               state_d  = (n_eff != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            work_d   = bus.sh_result;
            work_c_d = bus.sh_carry_out;
            count_d  = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Capture the final working value as DONE is entered so it already
      // includes the last shifter step.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         result_d = work_d;
         carry_d  = work_c_d;
      end

      // done trails the DONE state by one cycle; ready returns the cycle after done.
      done_d  = (state_q == S_DONE);
      ready_d = (state_d == S_IDLE) && (state_q == S_IDLE);
      busy_d  = (state_d == S_RUN) || (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         work_q   <= '0;
         work_c_q <= 1'b0;
         count_q  <= '0;
         op_q     <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         work_c_q <= work_c_d;
         count_q  <= count_d;
         op_q     <= op_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.ready       = ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.carry_out   = carry_q;
   assign bus.sh_operand  = work_q;
   assign bus.sh_carry_in = work_c_q;
   assign bus.sh_opcode   = op_q;

endmodule

// File: tb/tb_cjg_shift_sequencer.sv
// Bench for cjg_shift_sequencer: stands in for the single-step shifter and
// checks directed and random operations against a whole-amount reference.
module tb_cjg_shift_sequencer;
   localparam int WIDTH     = 32;
   localparam int AMT_WIDTH = 6;

   localparam logic [2:0] OP_SRL = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_RTR = 3'd3;
   localparam logic [2:0] OP_RTL = 3'd4;
   localparam logic [2:0] OP_RRC = 3'd5;
   localparam logic [2:0] OP_RLC = 3'd6;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   cjg_shift_sequencer_if #(.WIDTH(WIDTH), .AMT_WIDTH(AMT_WIDTH)) sq ();

   cjg_shift_sequencer #(.WIDTH(WIDTH), .AMT_WIDTH(AMT_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sq)
   );

   // Single-step shifter without modifier path: one bit per use.
   always_comb begin
      sq.sh_result    = sq.sh_operand;
      sq.sh_carry_out = sq.sh_carry_in;
      case (sq.sh_opcode)
         OP_SRL: sq.sh_result = {1'b0, sq.sh_operand[31:1]};
         OP_SLL: sq.sh_result = {sq.sh_operand[30:0], 1'b0};
         OP_SRA: sq.sh_result = {sq.sh_operand[31], sq.sh_operand[31:1]};
         OP_RTR: sq.sh_result = {sq.sh_operand[0], sq.sh_operand[31:1]};
         OP_RTL: sq.sh_result = {sq.sh_operand[30:0], sq.sh_operand[31]};
         OP_RRC: begin
            sq.sh_result    = {sq.sh_carry_in, sq.sh_operand[31:1]};
            sq.sh_carry_out = sq.sh_operand[0];
         end
         OP_RLC: begin
            sq.sh_result    = {sq.sh_operand[30:0], sq.sh_carry_in};
            sq.sh_carry_out = sq.sh_operand[31];
         end
         default: ;
      endcase
   end

   function automatic int ref_n(input logic [2:0] op, input int a);
      case (op)
         OP_SRL, OP_SLL, OP_SRA: return (a > 32) ? 32 : a;
         OP_RTR, OP_RTL:         return a % 32;
         OP_RRC, OP_RLC:         return a % 33;
         default:                return 0;
      endcase
   endfunction

   // Returns {carry, value} after shifting by the whole requested amount.
   function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] x,
                                         input logic c, input int a);
      int          n;
      logic [63:0] d;
      logic [32:0] ring;
      logic [65:0] dd;
      n    = ref_n(op, a);
      d    = {x, x};
      ring = {c, x};
      dd   = {ring, ring};
      case (op)
         OP_SRL: return {c, (n >= 32) ? 32'h0 : (x >> n)};
         OP_SLL: return {c, (n >= 32) ? 32'h0 : (x << n)};
         OP_SRA: return {c, x[31] ? ~((n >= 32) ? 32'h0 : ((~x) >> n))
                                  : ((n >= 32) ? 32'h0 : (x >> n))};
         OP_RTR: return {c, d[n +: 32]};
         OP_RTL: return {c, d[((32 - n) % 32) +: 32]};
         OP_RRC: return dd[n +: 33];
         OP_RLC: return dd[((33 - n) % 33) +: 33];
         default: return {c, x};
      endcase
   endfunction

   // Drives one request and reports what the sequencer did; lat is in clock
   // edges after the accepting edge (-1 if done never came).
   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic c,
                         input int a, output int lat, output logic [31:0] r,
                         output logic co, output logic rdy0, output logic busy0,
                         output logic rdy_at, output logic rdy_after);
      int waitc;
      waitc = 0;
      lat   = -1;
      r     = '0;
      co    = 1'b0;
      rdy_at = 1'bx;
      rdy_after = 1'bx;
      while (sq.ready !== 1'b1 && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      sq.start    = 1'b1;
      sq.opcode   = op;
      sq.operand  = x;
      sq.carry_in = c;
      sq.amount   = AMT_WIDTH'(a);
      @(posedge clk);
      @(negedge clk);
      sq.start = 1'b0;
      rdy0  = sq.ready;
      busy0 = sq.busy;
      for (int i = 0; i < 80; i++) begin
         if (i > 0) @(negedge clk);
         if (sq.done === 1'b1) begin
            lat    = i;
            r      = sq.result;
            co     = sq.carry_out;
            rdy_at = sq.ready;
            @(negedge clk);
            rdy_after = sq.ready;
            break;
         end
      end
      $display("op=%0d x=%h c=%b amt=%0d -> lat=%0d result=%h carry=%b", op, x, c, a, lat, r, co);
   endtask

   task automatic test_reset;
      if (sq.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", sq.ready); end
      vectors++;
      if (sq.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", sq.busy); end
      vectors++;
      if (sq.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", sq.done); end
      vectors++;
      if (sq.result !== 32'h0 || sq.carry_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_result: got %h/%b want 0/0", sq.result, sq.carry_out);
      end
      vectors++;
      if (sq.sh_operand !== 32'h0 || sq.sh_carry_in !== 1'b0 || sq.sh_opcode !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_sh: got %h/%b/%0d want 0/0/0", sq.sh_operand, sq.sh_carry_in, sq.sh_opcode);
      end
      vectors++;
   endtask

   task automatic test_sll_basic;
      int lat; logic [31:0] r; logic co, rdy0, busy0, rdy_at, rdy_after;
      run_op(OP_SLL, 32'h0000_0001, 1'b1, 4, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 5) begin miscompares++; $display("FAIL sll_latency: got %0d want 5", lat); end
      vectors++;
      if (r !== 32'h0000_0010 || co !== 1'b1) begin
         miscompares++; $display("FAIL sll_result: got %h/%b want 00000010/1", r, co);
      end
      vectors++;
      if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin
         miscompares++; $display("FAIL sll_accept_flags: ready=%b busy=%b want 0/1", rdy0, busy0);
      end
      vectors++;
      if (rdy_at !== 1'b0 || rdy_after !== 1'b1) begin
         miscompares++; $display("FAIL sll_ready_return: at_done=%b after=%b want 0/1", rdy_at, rdy_after);
      end
      vectors++;
   endtask

   task automatic test_rotate_wrap;
      int lat; logic [31:0] r; logic co, rdy0, busy0, rdy_at, rdy_after;
      run_op(OP_RTR, 32'h8000_0001, 1'b0, 33, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 2 || r !== 32'hC000_0000) begin
         miscompares++; $display("FAIL rtr33: got lat=%0d %h want lat=2 c0000000", lat, r);
      end
      vectors++;
      run_op(OP_RTR, 32'h8000_0001, 1'b0, 32, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 1 || r !== 32'h8000_0001) begin
         miscompares++; $display("FAIL rtr32: got lat=%0d %h want lat=1 80000001", lat, r);
      end
      vectors++;
   endtask

   task automatic test_rrc;
      int lat; logic [31:0] r; logic co, rdy0, busy0, rdy_at, rdy_after;
      run_op(OP_RRC, 32'h0000_0001, 1'b0, 1, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 2 || r !== 32'h0 || co !== 1'b1) begin
         miscompares++; $display("FAIL rrc1: got lat=%0d %h/%b want lat=2 00000000/1", lat, r, co);
      end
      vectors++;
      run_op(OP_RRC, 32'h0000_0001, 1'b0, 33, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 1 || r !== 32'h1 || co !== 1'b0) begin
         miscompares++; $display("FAIL rrc33: got lat=%0d %h/%b want lat=1 00000001/0", lat, r, co);
      end
      vectors++;
   endtask

   task automatic test_saturate;
      int lat; logic [31:0] r; logic co, rdy0, busy0, rdy_at, rdy_after;
      run_op(OP_SRA, 32'h8000_0000, 1'b0, 63, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 33 || r !== 32'hFFFF_FFFF) begin
         miscompares++; $display("FAIL sra63: got lat=%0d %h want lat=33 ffffffff", lat, r);
      end
      vectors++;
      run_op(OP_SRL, 32'h8000_0000, 1'b0, 63, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 33 || r !== 32'h0) begin
         miscompares++; $display("FAIL srl63: got lat=%0d %h want lat=33 00000000", lat, r);
      end
      vectors++;
   endtask

   task automatic test_back_to_back;
      int lat, pulses, waitc;
      logic [31:0] x, r;
      logic [32:0] exp;
      x = $urandom | 32'h0001_0000;
      exp = ref_op(OP_RTL, x, 1'b0, 10);
      waitc = 0;
      while (sq.ready !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
      sq.start = 1'b1; sq.opcode = OP_RTL; sq.operand = x; sq.carry_in = 1'b0; sq.amount = 6'd10;
      @(posedge clk);
      @(negedge clk);
      lat = -1; pulses = 0; r = '0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         if (sq.done === 1'b1) begin
            pulses++;
            if (lat < 0) begin lat = i; r = sq.result; end
         end
         if (lat < 0) begin
            sq.start    = 1'b1;
            sq.opcode   = 3'($urandom_range(0, 7));
            sq.operand  = $urandom;
            sq.carry_in = 1'($urandom);
            sq.amount   = 6'($urandom);
         end else begin
            sq.start = 1'b0;
         end
      end
      $display("op=%0d x=%h amt=10 with start held busy -> lat=%0d pulses=%0d result=%h", OP_RTL, x, lat, pulses, r);
      if (lat !== 11 || pulses !== 1) begin
         miscompares++; $display("FAIL busy_ignore: lat=%0d pulses=%0d want 11/1", lat, pulses);
      end
      vectors++;
      if (r !== exp[31:0]) begin
         miscompares++; $display("FAIL busy_result: got %h want %h", r, exp[31:0]);
      end
      vectors++;
   endtask

   task automatic test_reset_abort;
      int pulses, waitc, lat;
      logic [31:0] r; logic co, rdy0, busy0, rdy_at, rdy_after;
      waitc = 0;
      while (sq.ready !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
      sq.start = 1'b1; sq.opcode = OP_SLL; sq.operand = 32'h0000_0003; sq.carry_in = 1'b1; sq.amount = 6'd20;
      @(posedge clk);
      @(negedge clk);
      sq.start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      if (sq.ready !== 1'b1 || sq.busy !== 1'b0) begin
         miscompares++; $display("FAIL abort_flags: ready=%b busy=%b want 1/0", sq.ready, sq.busy);
      end
      vectors++;
      if (sq.result !== 32'h0 || sq.carry_out !== 1'b0) begin
         miscompares++; $display("FAIL abort_result: got %h/%b want 0/0", sq.result, sq.carry_out);
      end
      vectors++;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sq.done === 1'b1) pulses++;
      end
      $display("reset during SLL by 20 -> done pulses afterwards=%0d", pulses);
      if (pulses !== 0) begin
         miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
      end
      vectors++;
      run_op(OP_SLL, 32'h0000_0003, 1'b1, 20, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
      if (lat !== 21 || r !== 32'h0030_0000 || co !== 1'b1) begin
         miscompares++; $display("FAIL abort_recover: got lat=%0d %h/%b want 21 00300000/1", lat, r, co);
      end
      vectors++;
   endtask

   task automatic test_random;
      int lat, a, nexp;
      logic [2:0]  op;
      logic [31:0] x, r;
      logic        c, co, rdy0, busy0, rdy_at, rdy_after;
      logic [32:0] exp;
      for (int t = 0; t < 40; t++) begin
         op = 3'($urandom_range(0, 7));
         x  = $urandom;
         c  = 1'($urandom);
         a  = $urandom_range(0, 63);
         exp  = ref_op(op, x, c, a);
         nexp = ref_n(op, a) + 1;
         run_op(op, x, c, a, lat, r, co, rdy0, busy0, rdy_at, rdy_after);
         if (lat !== nexp) begin
            miscompares++; $display("FAIL rand_latency[%0d]: op=%0d amt=%0d got %0d want %0d", t, op, a, lat, nexp);
         end
         vectors++;
         if (r !== exp[31:0] || co !== exp[32]) begin
            miscompares++;
            $display("FAIL rand_result[%0d]: op=%0d x=%h c=%b amt=%0d got %h/%b want %h/%b",
                     t, op, x, c, a, r, co, exp[31:0], exp[32]);
         end
         vectors++;
      end
   endtask

   initial begin
      reset       = 1'b1;
      sq.start    = 1'b0;
      sq.opcode   = 3'd0;
      sq.operand  = 32'h0;
      sq.carry_in = 1'b0;
      sq.amount   = 6'd0;
      @(negedge clk);
      @(negedge clk);
      test_reset;
      reset = 1'b0;
      @(negedge clk);
      test_sll_basic;
      test_rotate_wrap;
      test_rrc;
      test_saturate;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
